display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexing scheduler for the 4-digit 7-segment letter mux. Generates the 2-bit digit
//  select at a divided refresh rate, holds the displayed 28-bit word, and accepts new words over
//  a valid/ready handshake, committing them only at frame boundaries so no frame is torn.
//  Inserts anode dead-time between digits and provides optional blink. Sits between game logic and the mux.
// PARAMETERS
//  TICK_DIV      100000  clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2
//  DEAD_CYC      16      cycles of forced blanking after each sel change; must be < TICK_DIV
//  BLINK_FRAMES  125     frames per blink half-period
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  enable      in   1   1 = scanning runs; 0 = scan frozen, display blanked
//  word_in     in   28  new word: [27:21] digit 0 (leftmost) ... [6:0] digit 3
//  word_valid  in   1   word_in valid this cycle
//  word_ready  out  1   controller can accept word_in
//  blink_en    in   1   1 = blink whole display
//  sel         out  2   digit select to letter mux
//  word_q      out  28  committed word to letter mux
//  disp_off    out  1   1 = top level forces anodes to 4'b1111 (all off)
//  frame_done  out  1   one-cycle pulse at end of each full 4-digit frame
// BEHAVIOUR
//  Reset (async, immediate): sel=0, word_q=0, pending empty (pending word discarded),
//   word_ready=1, disp_off=1, frame_done=0, prescaler=0, dead counter=0, frame counter=0, blink phase=0.
//  Prescaler: counts 0..TICK_DIV-1 while enable=1; tick = (count==TICK_DIV-1); wraps to 0.
//   enable=0: prescaler held at 0; sel and dead counter held.
//  Scan: on tick, sel <= sel+1 (3 wraps to 0); dead counter loaded with DEAD_CYC and decrements to 0.
//  frame_end = tick && sel==3; frame_done registered pulse, high the cycle after frame_end.
//  Handshake: accept = word_valid && word_ready; word_ready = ~pending (registered flag).
//   accept with no frame_end: word_in -> pending reg, pending=1 (word_ready drops next cycle).
//   frame_end with pending=1: word_q <= pending reg, pending=0.
//   frame_end with pending=0 and accept same cycle: word_q <= word_in directly, pending stays 0.
//   word_valid while word_ready=0: ignored; source must hold word until ready.
//  Blink: blink_en=1: frame counter counts frame_end events to BLINK_FRAMES-1, then wraps and
//   toggles blink phase. blink_en=0: counter and phase cleared to 0 on next clock.
//  disp_off (registered, 1-cycle latency from causes) = ~enable | (dead counter != 0) | (blink_en & phase).
//  Widths: prescaler $clog2(TICK_DIV), dead $clog2(DEAD_CYC+1), frame $clog2(BLINK_FRAMES); no overflow.
// STRUCTURE
//  Shared package display_pkg: NUM_DIGITS=4, SEG_W=7, WORD_W=28, ANODE_OFF=4'b1111, sel typedef.
//  Sub-module scan_prescaler (clk, rst_n, en, tick) parameterised by TICK_DIV; reusable elsewhere.
//  Remainder (sel counter, dead-time, handshake, blink) inline in display_scan_ctrl.
// TESTING (bench uses TICK_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2)
//  1 reset, enable=1: sel 0,1,2,3,0 every 4 clks; frame_done pulses once per 16 clks; disp_off 1 cycle after each sel change.
//  2 word_valid with word_in=28'h1234567 mid-frame: word_ready falls next cycle; word_q unchanged until
//    frame_end, then 28'h1234567; word_ready returns 1.
//  3 second word 28'hABCDEF0 held valid while pending: not taken until ready; committed next frame_end, first word never lost.
//  4 accept coincident with frame_end, pending empty: word_q updates that edge, word_ready stays 1.
//  5 blink_en=1: disp_off forced 1 for 2 frames, released 2 frames, repeating; blink_en=0 clears mid-phase.
//  6 rst_n low mid-frame with pending word: all outputs to reset values without clock; pending word absent after release.
//  7 enable=0 at sel=2: sel holds 2, disp_off=1; enable=1 resumes full 4-clk slot at sel=2.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment display path.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 7;
   localparam int WORD_W     = NUM_DIGITS * SEG_W;
   localparam int SEL_W      = 2;

   // Anode pattern the top level drives while disp_off is high.
   localparam logic [3:0] ANODE_OFF = 4'b1111;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_FIRST = 2'd0;
   localparam sel_t SEL_LAST  = 2'd3;

   // Counter width for a counter that must hold values 0..n-1 (never zero-width).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Next digit slot in the rightward scan order, wrapping after the last digit.
   function automatic sel_t sel_next(input sel_t s);
      return (s == SEL_LAST) ? SEL_FIRST : sel_t'(s + 2'd1);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_chk.sv
// Protocol properties of display_scan_ctrl, observed from its ports only.
module display_scan_ctrl_chk
   import display_pkg::*;
#(
   parameter int DEAD_CYC = 16
) (
   input logic              clk,
   input logic              rst_n,
   input logic              enable,
   input logic [SEL_W-1:0]  sel,
   input logic [WORD_W-1:0] word_q,
   input logic              disp_off,
   input logic              frame_done
);

   // A frame lasts many cycles, so the frame pulse is never two cycles wide.
   a_frame_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      frame_done |=> !frame_done);

   // A frozen scan keeps its select and blanks the display.
   a_freeze_sel: assert property (@(posedge clk) disable iff (!rst_n)
      !enable |=> (sel == $past(sel)));
   a_freeze_off: assert property (@(posedge clk) disable iff (!rst_n)
      !enable |=> disp_off);

   // The displayed word only ever changes together with the frame pulse.
   a_no_tear: assert property (@(posedge clk) disable iff (!rst_n)
      !$stable(word_q) |-> frame_done);

   // Every select change is followed by blanking when dead time is configured.
   if (DEAD_CYC > 0) begin : g_dead
      a_dead_time: assert property (@(posedge clk) disable iff (!rst_n)
         !$stable(sel) |=> disp_off);
   end

endmodule

// File: rtl/scan_prescaler.sv
// Free-running clock divider: one-cycle tick every TICK_DIV cycles while enabled.
// Disabling clears the count so a re-enable always starts a full period.
module scan_prescaler
   import display_pkg::*;
#(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W    = cnt_w(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   // Next count: hold at zero when disabled, otherwise count and wrap at the last value.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Gated by en so a freeze that lands on the last count cannot advance the scan.
   assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan scheduler for the 7-segment letter mux: walks the digit select,
// blanks the anodes for a short dead time after every select change, commits new
// words only on frame boundaries and optionally blinks the whole display.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int TICK_DIV     = 100000,
   parameter int DEAD_CYC     = 16,
   parameter int BLINK_FRAMES = 125
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic              blink_en,
   output logic [SEL_W-1:0]  sel,
   output logic [WORD_W-1:0] word_q,
   output logic              disp_off,
   output logic              frame_done
);

   localparam int                 DEAD_W     = cnt_w(DEAD_CYC + 1);
   localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYC);
   localparam logic [DEAD_W-1:0]  DEAD_ONE   = DEAD_W'(1);
   localparam int                 FRAME_W    = cnt_w(BLINK_FRAMES);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
   localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

   logic tick;
   logic frame_end;
   logic accept;

   sel_t               sel_d,         sel_q;
   logic [DEAD_W-1:0]  dead_d,        dead_q;
   logic               frame_done_d,  frame_done_q;
   logic               pending_d,     pending_q;
   logic [WORD_W-1:0]  pend_word_d,   pend_word_q;
   logic [WORD_W-1:0]  disp_word_d,   disp_word_q;
   logic [FRAME_W-1:0] frame_cnt_d,   frame_cnt_q;
   logic               blink_phase_d, blink_phase_q;
   logic               disp_off_d,    disp_off_q;

   scan_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (enable),
      .tick  (tick)
   );

   assign frame_end = tick && (sel_q == SEL_LAST);
   assign accept    = word_valid && !pending_q;

   // Digit select advances one slot per tick; the dead-time counter restarts on each change
   // and only drains while scanning runs, so a frozen scan keeps its blanking state.
   always_comb begin
      sel_d  = sel_q;
      dead_d = dead_q;
      if (tick) begin
         sel_d  = sel_next(sel_q);
         dead_d = DEAD_LOAD;
      end else if (enable && (dead_q != '0)) begin
         dead_d = dead_q - DEAD_ONE;
      end else begin
         dead_d = dead_q;
      end
   end

   // Word handshake: one-deep pending slot, drained into the displayed word only at frame end.
   // With the slot empty, a word arriving on the frame-end edge goes straight to the display.
   always_comb begin
      pending_d   = pending_q;
      pend_word_d = pend_word_q;
      disp_word_d = disp_word_q;
      if (frame_end) begin
         if (pending_q) begin
            disp_word_d = pend_word_q;
            pending_d   = 1'b0;
         end else if (accept) begin
            disp_word_d = word_in;
         end else begin
            disp_word_d = disp_word_q;
         end
      end else if (accept) begin
         pend_word_d = word_in;
         pending_d   = 1'b1;
      end else begin
         pending_d   = pending_q;
      end
   end

   // Blink timing: count completed frames and flip the phase every BLINK_FRAMES of them.
   always_comb begin
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!blink_en) begin
         frame_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (frame_end) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            frame_cnt_d   = frame_cnt_q + FRAME_ONE;
         end
      end else begin
         frame_cnt_d   = frame_cnt_q;
      end
   end

   // Output flags: frame pulse and the blanking request, both one cycle behind their causes.
   always_comb begin
      frame_done_d = frame_end;
      disp_off_d   = !enable || (dead_q != '0) || (blink_en && blink_phase_q);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q         <= SEL_FIRST;
         dead_q        <= '0;
         frame_done_q  <= 1'b0;
         pending_q     <= 1'b0;
         pend_word_q   <= '0;
         disp_word_q   <= '0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         disp_off_q    <= 1'b1;
      end else begin
         sel_q         <= sel_d;
         dead_q        <= dead_d;
         frame_done_q  <= frame_done_d;
         pending_q     <= pending_d;
         pend_word_q   <= pend_word_d;
         disp_word_q   <= disp_word_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         disp_off_q    <= disp_off_d;
      end
   end

   assign sel        = sel_q;
   assign word_q     = disp_word_q;
   assign word_ready = !pending_q;
   assign disp_off   = disp_off_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (TICK_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2).
// Stimulus pushes hand-computed expectations tagged with the cycle they are due;
// a monitor compares them on the falling edge and also checks every word commit.
module tb_display_scan_ctrl;
   import display_pkg::*;

   localparam int K_SEL  = 0;
   localparam int K_OFF  = 1;
   localparam int K_FD   = 2;
   localparam int K_WORD = 3;
   localparam int K_RDY  = 4;

   localparam logic [27:0] W1 = 28'h1234567;
   localparam logic [27:0] W2 = 28'hABCDEF0;
   localparam logic [27:0] W3 = 28'h0F0F0F0;
   localparam logic [27:0] W4 = 28'h7654321;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b1;
   logic        enable     = 1'b0;
   logic [27:0] word_in    = 28'd0;
   logic        word_valid = 1'b0;
   logic        blink_en   = 1'b0;
   logic        word_ready;
   logic [1:0]  sel;
   logic [27:0] word_q;
   logic        disp_off;
   logic        frame_done;

   int cyc      = 0;
   int base     = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          due;
      int          kind;
      logic [27:0] val;
      string       nm;
   } exp_t;

   exp_t        sbq[$];
   logic [27:0] commit_q[$];

   display_scan_ctrl #(
      .TICK_DIV     (4),
      .DEAD_CYC     (1),
      .BLINK_FRAMES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .blink_en   (blink_en),
      .sel        (sel),
      .word_q     (word_q),
      .disp_off   (disp_off),
      .frame_done (frame_done)
   );

   display_scan_ctrl_chk #(
      .DEAD_CYC (1)
   ) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .sel        (sel),
      .word_q     (word_q),
      .disp_off   (disp_off),
      .frame_done (frame_done)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got no end of test, expected finish before time 100000");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_at(input int t, input int kind, input logic [27:0] v, input string nm);
      exp_t e;
      e.due  = base + t;
      e.kind = kind;
      e.val  = v;
      e.nm   = $sformatf("%s[t=%0d]", nm, t);
      sbq.push_back(e);
   endtask

   function automatic logic [27:0] observe(input int kind);
      case (kind)
         K_SEL:   return {26'd0, sel};
         K_OFF:   return {27'd0, disp_off};
         K_FD:    return {27'd0, frame_done};
         K_WORD:  return word_q;
         K_RDY:   return {27'd0, word_ready};
         default: return 28'd0;
      endcase
   endfunction

   task automatic at(input int t);
      while (cyc < base + t) @(negedge clk);
   endtask

   task automatic reset_values(input string tag);
      chk({tag, "_sel"},   {26'd0, sel},        28'd0);
      chk({tag, "_word"},  word_q,              28'd0);
      chk({tag, "_ready"}, {27'd0, word_ready}, 28'd1);
      chk({tag, "_off"},   {27'd0, disp_off},   28'd1);
      chk({tag, "_fd"},    {27'd0, frame_done}, 28'd0);
   endtask

   // Monitor: due expectations and every change of the displayed word.
   initial begin : monitor
      exp_t        keep[$];
      logic [27:0] prev_word;
      prev_word = 28'd0;
      forever begin
         @(negedge clk);
         keep = {};
         foreach (sbq[i]) begin
            if (sbq[i].due == cyc) begin
               chk(sbq[i].nm, observe(sbq[i].kind), sbq[i].val);
            end else if (sbq[i].due < cyc) begin
               n_checks++;
               n_errors++;
               $display("FAIL %s: got no sample, expected %h at cycle %0d", sbq[i].nm, sbq[i].val, sbq[i].due);
            end else begin
               keep.push_back(sbq[i]);
            end
         end
         sbq = keep;
         if (!rst_n) begin
            prev_word = word_q;
         end else if (word_q !== prev_word) begin
            if (commit_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL commit: got %h, expected no commit", word_q);
            end else begin
               chk("commit", word_q, commit_q.pop_front());
            end
            prev_word = word_q;
         end
      end
   end

   // Stimulus.
   initial begin : stimulus
      #1 rst_n = 1'b0;
      #2 reset_values("rst0");
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      base   = cyc;

      // Scan order, dead time and frame pulse over the first frame plus one slot.
      for (int t = 1; t < 20; t++) begin
         expect_at(t, K_SEL, 28'((t / 4) % 4), "t1_sel");
         expect_at(t, K_OFF, (t >= 5 && t % 4 == 1) ? 28'd1 : 28'd0, "t1_off");
         expect_at(t, K_FD,  (t == 16) ? 28'd1 : 28'd0, "t1_fd");
      end

      // First word mid-frame, second word held while the first is pending.
      expect_at(20, K_RDY,  28'd1, "t2_rdy");
      expect_at(21, K_RDY,  28'd0, "t2_rdy");
      expect_at(31, K_RDY,  28'd0, "t2_rdy");
      expect_at(31, K_WORD, 28'd0, "t2_word");
      expect_at(32, K_WORD, W1,    "t2_word");
      expect_at(32, K_RDY,  28'd1, "t2_rdy");
      expect_at(33, K_RDY,  28'd0, "t3_rdy");
      expect_at(47, K_WORD, W1,    "t3_word");
      expect_at(47, K_RDY,  28'd0, "t3_rdy");
      expect_at(48, K_WORD, W2,    "t3_word");
      expect_at(48, K_RDY,  28'd1, "t3_rdy");
      commit_q.push_back(W1);
      commit_q.push_back(W2);
      at(20);
      word_in    = W1;
      word_valid = 1'b1;
      at(21);
      word_in    = W2;
      at(33);
      word_valid = 1'b0;
      word_in    = 28'd0;

      // Word offered exactly on the frame-end edge with nothing pending.
      expect_at(63, K_WORD, W2,    "t4_word");
      expect_at(64, K_WORD, W3,    "t4_word");
      expect_at(64, K_FD,   28'd1, "t4_fd");
      expect_at(64, K_RDY,  28'd1, "t4_rdy");
      expect_at(65, K_RDY,  28'd1, "t4_rdy");
      commit_q.push_back(W3);
      at(63);
      word_in    = W3;
      word_valid = 1'b1;
      at(64);
      word_valid = 1'b0;
      word_in    = 28'd0;
      blink_en   = 1'b1;

      // Blink: two frames on, two frames off, then clearing mid-phase.
      expect_at(96,  K_OFF, 28'd0, "t5_off");
      expect_at(98,  K_OFF, 28'd1, "t5_off");
      expect_at(110, K_OFF, 28'd1, "t5_off");
      expect_at(126, K_OFF, 28'd1, "t5_off");
      expect_at(128, K_OFF, 28'd1, "t5_off");
      expect_at(130, K_OFF, 28'd0, "t5_off");
      expect_at(142, K_OFF, 28'd0, "t5_off");
      expect_at(158, K_OFF, 28'd0, "t5_off");
      expect_at(162, K_OFF, 28'd1, "t5_off");
      expect_at(182, K_OFF, 28'd1, "t5_off");
      expect_at(183, K_OFF, 28'd0, "t5_off");
      expect_at(186, K_OFF, 28'd0, "t5_off");
      expect_at(194, K_OFF, 28'd0, "t5_off");
      expect_at(206, K_OFF, 28'd0, "t5_off");
      expect_at(210, K_OFF, 28'd1, "t5_off");
      expect_at(212, K_OFF, 28'd0, "t5_off");
      at(182);
      blink_en = 1'b0;
      at(186);
      blink_en = 1'b1;
      at(210);
      blink_en = 1'b0;

      // Freeze at sel=2, then resume with a full slot.
      expect_at(218, K_SEL, 28'd2, "t7_sel");
      expect_at(218, K_OFF, 28'd1, "t7_off");
      expect_at(221, K_SEL, 28'd2, "t7_sel");
      expect_at(224, K_SEL, 28'd2, "t7_sel");
      expect_at(225, K_OFF, 28'd1, "t7_off");
      expect_at(226, K_OFF, 28'd0, "t7_off");
      expect_at(228, K_SEL, 28'd2, "t7_sel");
      expect_at(229, K_SEL, 28'd3, "t7_sel");
      expect_at(230, K_OFF, 28'd1, "t7_off");
      expect_at(232, K_FD,  28'd0, "t7_fd");
      expect_at(233, K_FD,  28'd1, "t7_fd");
      expect_at(233, K_SEL, 28'd0, "t7_sel");
      at(217);
      enable = 1'b0;
      at(225);
      enable = 1'b1;

      // Reset mid-frame with a word pending.
      expect_at(236, K_RDY,  28'd0, "t6_rdy");
      expect_at(238, K_RDY,  28'd0, "t6_rdy");
      expect_at(238, K_WORD, W3,    "t6_word");
      expect_at(238, K_SEL,  28'd1, "t6_sel");
      at(235);
      word_in    = W4;
      word_valid = 1'b1;
      at(236);
      word_valid = 1'b0;
      word_in    = 28'd0;
      at(239);
      #2 rst_n = 1'b0;
      #1 reset_values("rst1");
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      base   = cyc;

      expect_at(1,  K_RDY,  28'd1, "t6b_rdy");
      expect_at(3,  K_SEL,  28'd0, "t6b_sel");
      expect_at(4,  K_SEL,  28'd1, "t6b_sel");
      expect_at(5,  K_OFF,  28'd1, "t6b_off");
      expect_at(6,  K_OFF,  28'd0, "t6b_off");
      expect_at(15, K_FD,   28'd0, "t6b_fd");
      expect_at(16, K_FD,   28'd1, "t6b_fd");
      expect_at(16, K_WORD, 28'd0, "t6b_word");
      expect_at(17, K_WORD, 28'd0, "t6b_word");
      expect_at(17, K_RDY,  28'd1, "t6b_rdy");
      at(22);

      chk("sb_drained",     28'(sbq.size()),      28'd0);
      chk("commit_drained", 28'(commit_q.size()), 28'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
